tx_report_sched: RTL and testbench
==================================

TX_REPORT_SCHED -- requirements
Module: tx_report_sched

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100_000_000, meaning the clk frequency in Hz.
REQ-002 SHALL have parameter REPORT_PERIOD, default CLK_HZ, meaning the number of cycles between automatic reports while running.
REQ-003 SHALL have parameter COUNT_W, default 14, meaning the width of the counter value input.
REQ-004 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port i_rx_data  input  8  received UART byte, valid only when i_rx_done=1.
REQ-007 SHALL have port i_rx_done  input  1  one-cycle strobe marking a received byte.
REQ-008 SHALL have port i_count  input  COUNT_W  live upcounter value.
REQ-009 SHALL have port i_run_on  input  1  counter run status.
REQ-010 SHALL have port i_tx_busy  input  1  UART transmitter busy.
REQ-011 SHALL have port o_tx_start  output  1  one-cycle transmit request.
REQ-012 SHALL have port o_tx_data  output  8  byte to transmit; stable from the o_tx_start cycle until i_tx_busy falls.
REQ-013 SHALL have port o_report_busy  output  1  high while a report frame is in progress (CONV through the last byte).

Function
REQ-014 SHALL share the single UART TX between two requesters: an echo request and a report request.
REQ-015 Echo request: on i_rx_done, SHALL latch i_rx_data into a 1-entry echo buffer and set echo_pend; a byte arriving while echo_pend=1 SHALL overwrite the buffer (the older byte is dropped).
REQ-016 Report request: SHALL set rep_pend on i_rx_done with i_rx_data=0x71 ('q'), or on a period tick; a trigger arriving while rep_pend=1 or a report is active SHALL be merged (no second frame).
REQ-017 Period tick: a cycle counter SHALL advance only while i_run_on=1, tick at REPORT_PERIOD-1, then wrap to 0; it SHALL clear to 0 whenever i_run_on=0.
REQ-018 SHALL implement states IDLE, ECHO, CONV, REP and the TX sub-states START, WAIT_HI, WAIT_LO.
REQ-019 In IDLE with i_tx_busy=0, echo_pend SHALL win over rep_pend: the controller goes to ECHO and clears echo_pend. Otherwise, if rep_pend is set, it goes to CONV and clears rep_pend.
REQ-020 On entering CONV, SHALL snapshot i_count, saturated to 9999 if larger, and start the BCD converter; it SHALL go to REP on converter done.
REQ-021 REP SHALL send a 6-byte frame: thousands, hundreds, tens and units as ASCII (0x30+digit), then 0x0D, then 0x0A. Byte index runs 0..5; the controller returns to IDLE after index 5 completes.
REQ-022 Per byte: in START, o_tx_start=1 for exactly one cycle. WAIT_HI then waits for i_tx_busy=1, and WAIT_LO waits for i_tx_busy=0, before the next byte or the exit.
REQ-023 A started report frame SHALL NOT be interrupted; echoes arriving meanwhile wait in the buffer and are sent after the frame.
REQ-024 A 'q' byte SHALL be echoed before its report frame.
REQ-025 o_tx_start SHALL never assert while i_tx_busy=1.
REQ-026 Simultaneous i_rx_done and period tick: the echo and a single report are both queued.

Reset
REQ-027 On reset: o_tx_start=0, o_tx_data=0x00, o_report_busy=0, state IDLE, echo_pend=0, rep_pend=0, period counter 0, byte index 0.
REQ-028 Reset mid-frame SHALL abort the frame immediately, with no further o_tx_start; the remaining bytes are discarded.

Structure
REQ-029 A shared package SHALL hold the state encodings, ASCII constants ('q', CR, LF, '0') and the saturation limit 9999.
REQ-030 BCD conversion SHALL be a sub-module bin2bcd_dd: sequential double-dabble with start/done, COUNT_W cycles, 4 output digits.

Verification
REQ-031 rx 0x41, TX model with busy for 10 cycles -> one o_tx_start with o_tx_data=0x41; no report.
REQ-032 i_count=1234, rx 'q' -> bytes 0x71, 0x31, 0x32, 0x33, 0x34, 0x0D, 0x0A in order; o_report_busy high throughout the frame.
REQ-033 i_count=12000, rx 'q' -> frame digits "9999".
REQ-034 i_run_on=1, REPORT_PERIOD=50 -> a frame every 50 cycles plus frame time; dropping i_run_on stops the frames.
REQ-035 rx 'q' then 0x42 and 0x43 during the frame -> 'q', full frame, then 0x43 only (0x42 overwritten).
REQ-036 reset asserted after byte index 2 -> outputs go to 0 asynchronously; after release, no further o_tx_start until a new request.

Source files
------------

// File: rtl/tx_report_sched_pkg.sv
// Shared encodings and constants for the UART TX report scheduler.
package tx_report_sched_pkg;

  // Top-level controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ECHO = 2'd1,
    ST_CONV = 2'd2,
    ST_REP  = 2'd3
  } state_t;

  // Per-byte handshake with the UART transmitter.
  typedef enum logic [1:0] {
    TX_START   = 2'd0,
    TX_WAIT_HI = 2'd1,
    TX_WAIT_LO = 2'd2
  } tx_state_t;

  localparam logic [7:0]  ASCII_Q    = 8'h71;
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;
  localparam logic [7:0]  ASCII_ZERO = 8'h30;

  // Largest value that fits the four-digit report.
  localparam logic [31:0] SAT_LIMIT  = 32'd9999;

  localparam int          BCD_W      = 16;
  localparam logic [2:0]  LAST_IDX   = 3'd5;

  // Byte idx of the report frame: four ASCII digits, then CR, then LF.
  function automatic logic [7:0] frame_byte(input logic [2:0] idx, input logic [BCD_W-1:0] bcd);
    logic [7:0] b;
    case (idx)
      3'd0:    b = ASCII_ZERO + {4'd0, bcd[15:12]};
      3'd1:    b = ASCII_ZERO + {4'd0, bcd[11:8]};
      3'd2:    b = ASCII_ZERO + {4'd0, bcd[7:4]};
      3'd3:    b = ASCII_ZERO + {4'd0, bcd[3:0]};
      3'd4:    b = ASCII_CR;
      default: b = ASCII_LF;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/tx_report_sched_bin2bcd_dd.sv
// Sequential double-dabble binary to 4-digit BCD converter.
// One shift per cycle; done pulses once, W cycles after start is seen.
// The result stays on bcd until the next start.
module bin2bcd_dd
  import tx_report_sched_pkg::*;
#(
  parameter int W = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [W-1:0]     bin,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int CNT_W = $clog2(W + 1);

  logic [W-1:0]     shreg;
  logic [CNT_W-1:0] remaining;
  logic             busy;
  logic [BCD_W-1:0] adjusted;

  // Add 3 to every digit that would exceed 9 after the next left shift.
  always_comb begin
    // NOTE: assign a default before any conditional update so no latch is inferred.
    adjusted = bcd;
    for (int d = 0; d < BCD_W / 4; d++) begin
      if (bcd[4*d +: 4] > 4'd4) adjusted[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // Load on start, then shift the binary value into the BCD register bit by bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      remaining <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd       <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        shreg     <= bin;
        bcd       <= '0;
        remaining <= CNT_W'(W);
        busy      <= 1'b1;
      end else if (busy) begin
        bcd       <= {adjusted[BCD_W-2:0], shreg[W-1]};
        shreg     <= shreg << 1;
        remaining <= remaining - CNT_W'(1);
        if (remaining == CNT_W'(1)) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tx_report_sched.sv
// Shares one UART transmitter between byte echo and a periodic/on-demand
// decimal report of the counter value ("dddd\r\n").
// An echo waits in a one-entry buffer; a report frame, once started, is never interrupted.
module tx_report_sched
  import tx_report_sched_pkg::*;
#(
  parameter int CLK_HZ        = 100_000_000,
  parameter int REPORT_PERIOD = CLK_HZ,
  parameter int COUNT_W       = 14
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_done,
  input  logic [COUNT_W-1:0] i_count,
  input  logic               i_run_on,
  input  logic               i_tx_busy,
  output logic               o_tx_start,
  output logic [7:0]         o_tx_data,
  output logic               o_report_busy
);

  localparam int               PER_W    = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
  localparam logic [PER_W-1:0] PER_LAST = PER_W'(REPORT_PERIOD - 1);

  state_t             state;
  tx_state_t          tx_state;
  logic [2:0]         byte_idx;
  logic               echo_pend;
  logic [7:0]         echo_buf;
  logic               rep_pend;
  logic [PER_W-1:0]   per_cnt;
  logic               tick;
  logic               rep_trig;
  logic               rep_launch;
  logic               rep_active;
  logic               conv_start;
  logic [COUNT_W-1:0] conv_bin;
  logic               conv_done;
  logic [BCD_W-1:0]   bcd;

  assign tick     = i_run_on && (per_cnt == PER_LAST);
  assign rep_trig = tick || (i_rx_done && (i_rx_data == ASCII_Q));

  // A report leaves IDLE only when no echo is waiting and the transmitter is free.
  assign rep_launch = (state == ST_IDLE) && !i_tx_busy && !echo_pend && rep_pend;
  // Triggers landing while a report is launching or running fold into that report.
  assign rep_active = rep_launch || (state == ST_CONV) || (state == ST_REP);

  // Period counter: runs only while the upcounter runs, held at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      per_cnt <= '0;
    end else if (!i_run_on || tick) begin
      per_cnt <= '0;
    end else begin
      per_cnt <= per_cnt + PER_W'(1);
    end
  end

  bin2bcd_dd #(.W(COUNT_W)) u_bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (conv_bin),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Arbitration, per-byte TX handshake and request capture with registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      tx_state      <= TX_START;
      byte_idx      <= '0;
      echo_pend     <= 1'b0;
      echo_buf      <= '0;
      rep_pend      <= 1'b0;
      conv_start    <= 1'b0;
      conv_bin      <= '0;
      o_tx_start    <= 1'b0;
      o_tx_data     <= '0;
      o_report_busy <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every branch sees the pre-edge values.
      o_tx_start <= 1'b0;
      conv_start <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (!i_tx_busy && echo_pend) begin
            state      <= ST_ECHO;
            tx_state   <= TX_START;
            o_tx_start <= 1'b1;
            o_tx_data  <= echo_buf;
            echo_pend  <= 1'b0;
          end else if (rep_launch) begin
            state         <= ST_CONV;
            rep_pend      <= 1'b0;
            o_report_busy <= 1'b1;
            conv_start    <= 1'b1;
            conv_bin      <= (32'(i_count) > SAT_LIMIT) ? COUNT_W'(SAT_LIMIT) : i_count;
          end
        end

        ST_ECHO: begin
          case (tx_state)
            TX_START:   tx_state <= TX_WAIT_HI;
            TX_WAIT_HI: if (i_tx_busy) tx_state <= TX_WAIT_LO;
            default:    if (!i_tx_busy) state <= ST_IDLE;
          endcase
        end

        ST_CONV: begin
          if (conv_done) begin
            state      <= ST_REP;
            byte_idx   <= '0;
            tx_state   <= TX_START;
            o_tx_start <= 1'b1;
            o_tx_data  <= frame_byte(3'd0, bcd);
          end
        end

        default: begin
          case (tx_state)
            TX_START:   tx_state <= TX_WAIT_HI;
            TX_WAIT_HI: if (i_tx_busy) tx_state <= TX_WAIT_LO;
            default: begin
              if (!i_tx_busy) begin
                if (byte_idx == LAST_IDX) begin
                  state         <= ST_IDLE;
                  byte_idx      <= '0;
                  o_report_busy <= 1'b0;
                end else begin
                  byte_idx   <= byte_idx + 3'd1;
                  tx_state   <= TX_START;
                  o_tx_start <= 1'b1;
                  o_tx_data  <= frame_byte(byte_idx + 3'd1, bcd);
                end
              end
            end
          endcase
        end
      endcase

      // Capture comes last so a new arrival wins over a same-cycle clear.
      if (i_rx_done) begin
        echo_buf  <= i_rx_data;
        echo_pend <= 1'b1;
      end
      if (rep_trig && !rep_active) rep_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tx_report_sched.sv
// Randomized bench: expected TX bytes are queued when stimulus is issued,
// a monitor pops and compares on every o_tx_start.
`timescale 1ns/1ps
module tb_tx_report_sched;

  localparam int COUNT_W       = 14;
  localparam int REPORT_PERIOD = 50;
  localparam int RUN_CYCLES    = 260;

  logic               clk = 1'b0;
  logic               reset;
  logic [7:0]         rx_data;
  logic               rx_done;
  logic [COUNT_W-1:0] count;
  logic               run_on;
  logic               tx_busy;
  logic               tx_start;
  logic [7:0]         tx_data;
  logic               report_busy;

  tx_report_sched #(
    .CLK_HZ        (1_000_000),
    .REPORT_PERIOD (REPORT_PERIOD),
    .COUNT_W       (COUNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_rx_data     (rx_data),
    .i_rx_done     (rx_done),
    .i_count       (count),
    .i_run_on      (run_on),
    .i_tx_busy     (tx_busy),
    .o_tx_start    (tx_start),
    .o_tx_data     (tx_data),
    .o_report_busy (report_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] data;
    logic       in_frame;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks    = 0;
  int   n_errors    = 0;
  int   start_count = 0;
  int   busy_len    = 10;
  int   busy_left;
  logic [7:0] tx_latched;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: what the line must carry for each request.
  function automatic void push_echo(input logic [7:0] b);
    exp_q.push_back('{b, 1'b0});
  endfunction

  function automatic void push_frame(input int value);
    int v;
    v = (value > 9999) ? 9999 : value;
    exp_q.push_back('{8'h30 + 8'(v / 1000), 1'b1});
    exp_q.push_back('{8'h30 + 8'((v / 100) % 10), 1'b1});
    exp_q.push_back('{8'h30 + 8'((v / 10) % 10), 1'b1});
    exp_q.push_back('{8'h30 + 8'(v % 10), 1'b1});
    exp_q.push_back('{8'h0D, 1'b1});
    exp_q.push_back('{8'h0A, 1'b1});
  endfunction

  // UART transmitter model: busy for busy_len cycles after each start.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_busy   <= 1'b0;
      busy_left <= 0;
    end else if (tx_start) begin
      tx_busy    <= 1'b1;
      busy_left  <= busy_len;
      tx_latched <= tx_data;
    end else if (busy_left > 1) begin
      busy_left <= busy_left - 1;
    end else begin
      busy_left <= 0;
      tx_busy   <= 1'b0;
    end
  end

  // Monitor: compare each transmitted byte against the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b0) begin
      if (tx_start) begin
        start_count++;
        check("start_while_busy", tx_busy, 0);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_start: got byte 0x%02h, expected no transmit at %0t", tx_data, $time);
        end else begin
          mon_e = exp_q.pop_front();
          check("tx_byte", tx_data, mon_e.data);
          check("report_busy_during_byte", report_busy, mon_e.in_frame);
        end
      end
      if (tx_busy) check("tx_data_stable", tx_data, tx_latched);
    end
  end

  task automatic send_rx(input logic [7:0] b);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int waited;
    waited = 0;
    while (exp_q.size() != 0 && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    check({name, "_drained_in_time"}, 32'(waited < 3000), 1);
    repeat (30) @(negedge clk);
    check({name, "_report_busy_idle"}, report_busy, 0);
  endtask

  function automatic logic [7:0] rand_non_q();
    logic [7:0] b;
    b = 8'($urandom_range(0, 255));
    if (b == 8'h71) b = 8'h70;
    return b;
  endfunction

  int         vals[4] = '{0, 9999, 10000, 16383};
  logic [7:0] b1, b2;
  int         base, waited;

  initial begin
    reset   = 1'b1;
    rx_data = '0;
    rx_done = 1'b0;
    count   = '0;
    run_on  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_tx_start", tx_start, 0);
    check("reset_tx_data", tx_data, 0);
    check("reset_report_busy", report_busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Plain echo, no report.
    push_echo(8'h41);
    send_rx(8'h41);
    wait_drain("echo_41");

    // 'q' echoed first, then the frame.
    count = 14'd1234;
    push_echo(8'h71);
    push_frame(1234);
    send_rx(8'h71);
    wait_drain("frame_1234");

    // Saturation at 9999.
    count = 14'd12000;
    push_echo(8'h71);
    push_frame(12000);
    send_rx(8'h71);
    wait_drain("frame_sat");

    // Boundary values.
    foreach (vals[i]) begin
      count = COUNT_W'(vals[i]);
      push_echo(8'h71);
      push_frame(vals[i]);
      send_rx(8'h71);
      wait_drain("frame_boundary");
    end

    // Random single requests.
    for (int i = 0; i < 10; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        count = COUNT_W'($urandom_range(0, 16383));
        push_echo(8'h71);
        push_frame(int'(count));
        send_rx(8'h71);
      end else begin
        b1 = rand_non_q();
        push_echo(b1);
        send_rx(b1);
      end
      wait_drain("random_req");
    end

    // Bytes during a frame: only the last waits; a 'q' during a frame adds no frame.
    for (int i = 0; i < 3; i++) begin
      b1    = rand_non_q();
      b2    = (i == 2) ? 8'h71 : rand_non_q();
      count = COUNT_W'($urandom_range(0, 9999));
      push_echo(8'h71);
      push_frame(int'(count));
      push_echo(b2);
      send_rx(8'h71);
      repeat (39) @(negedge clk);
      send_rx(b1);
      repeat (9) @(negedge clk);
      send_rx(b2);
      wait_drain("overwrite");
    end

    // Periodic reports with a fast transmitter; a byte arrives on the first tick.
    busy_len = 1;
    count    = COUNT_W'($urandom_range(0, 9999));
    b1       = rand_non_q();
    push_echo(b1);
    for (int k = 0; k < RUN_CYCLES / REPORT_PERIOD; k++) push_frame(int'(count));
    run_on = 1'b1;
    for (int c = 0; c < RUN_CYCLES; c++) begin
      if (c == REPORT_PERIOD - 1) begin
        rx_data = b1;
        rx_done = 1'b1;
      end else begin
        rx_done = 1'b0;
      end
      @(negedge clk);
    end
    run_on  = 1'b0;
    rx_done = 1'b0;
    wait_drain("period");
    base = start_count;
    repeat (200) @(negedge clk);
    check("no_frames_after_stop", start_count, base);

    // Reset in the middle of a frame.
    busy_len = 10;
    count    = COUNT_W'($urandom_range(1000, 9999));
    push_echo(8'h71);
    push_frame(int'(count));
    base = start_count;
    send_rx(8'h71);
    waited = 0;
    while (start_count < base + 4 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    check("reached_byte_idx2", 32'(start_count >= base + 4), 1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort_tx_start", tx_start, 0);
    check("abort_tx_data", tx_data, 0);
    check("abort_report_busy", report_busy, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    base  = start_count;
    repeat (300) @(negedge clk);
    check("no_start_after_reset", start_count, base);

    // Fresh request after reset.
    push_echo(8'h55);
    send_rx(8'h55);
    wait_drain("after_reset");

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
